link_frame_rx: RTL and testbench
================================

# link_frame_rx

Receive-side frame assembler for the inter-board score link. Sits between each UART receiver and the character ROM path: consumes the byte stream from one UART (`data_out` plus a one-cycle byte strobe), locates frames, validates them, and publishes the remote board's `{ID, BCD points}` word. It is the counterpart of the transmit-side frame builder. One instance is placed per UART link and replaces the free-running byte mux.

## Interface
Parameters:
- `SOF`, `8'hA5`: start-of-frame byte.
- `BYTE_TIMEOUT`, `26040`: max idle cycles between bytes inside a frame (4 byte times at 115200 baud, 75 MHz).
- `LINK_TIMEOUT`, `75_000_000`: cycles without a good frame before the link is declared down.

Ports:
- `pclk`  in  1: pixel-domain clock; the only clock.
- `rst`  in  1: asynchronous, active-low reset.
- `rx_data`  in  8: byte from the UART receiver.
- `rx_valid`  in  1: one-cycle strobe; `rx_data` is valid on this cycle.
- `ext_data`  out  32: `{ID[7:0], points_BCD[23:0]}` of the last good frame.
- `ext_valid`  out  1: one-cycle pulse when `ext_data` updates.
- `link_up`  out  1: a good frame was received within the last `LINK_TIMEOUT` cycles.
- `frame_err`  out  1: one-cycle pulse on any frame rejection.
- `err_cnt`  out  8: saturating count of rejections.

## Operation
- Frame on the wire: `SOF`, `ID`, `P2` (points[23:16]), `P1`, `P0`, and a `CHK` byte when the checksum feature is enabled.
- FSM states: `IDLE`, `GET_ID`, `GET_P2`, `GET_P1`, `GET_P0`, `GET_CHK`.
  - In `IDLE`, only a byte equal to `SOF` advances the FSM (to `GET_ID`). Other bytes are dropped silently.
  - Each accepted byte is stored in a shadow register and advances the FSM one state.
  - After the final byte, the FSM validates the frame and returns to `IDLE`.
- Validation:
  - `ID` must not be 0x00 and must not equal `SOF`.
  - Every nibble of P2..P0 must be ≤ 9.
  - Good frame: `ext_data` is loaded from the shadow registers, `ext_valid` pulses, and the link timer is cleared.
  - Bad frame: `frame_err` pulses, `err_cnt` increments (saturates at 255), and `ext_data` holds its old value.
- Resync: a byte equal to `SOF` received in `GET_P2`/`GET_P1`/`GET_P0` counts as an error (`frame_err`, `err_cnt`+1) and moves the FSM to `GET_ID`. In `GET_CHK`, `SOF` is ordinary data.
- Byte timeout: the byte timer runs in every non-`IDLE` state and is cleared on each `rx_valid`. When it reaches `BYTE_TIMEOUT`, the FSM goes to `IDLE` with `frame_err` and `err_cnt`+1.
- Link timer:
  - Counts up, saturates at `LINK_TIMEOUT`, and is cleared on a good frame.
  - `link_up` = (timer < `LINK_TIMEOUT`) AND at least one good frame since reset.
  - `ext_data` is kept when the link drops.

## Timing
- Reset values: `ext_data`=0, `ext_valid`=0, `link_up`=0, `frame_err`=0, `err_cnt`=0, FSM=`IDLE`, timers=0.
- Latency: the final byte is accepted at edge N; `ext_data`, `ext_valid` and `frame_err` are registered at that same edge N and are visible during cycle N+1. `ext_valid` lasts exactly one cycle.
- `rx_valid` on the cycle the byte timer would expire: the byte is processed and the timeout does not fire.
- A good frame on the cycle the link timer saturates: the timer clears and `link_up` stays 1.
- Back-to-back frames with no idle gap are supported: `SOF` can be accepted the cycle after commit.
- Reset asserted mid-frame: everything returns to reset values immediately, and the partial frame is discarded.

## Configuration
- `LINK_FRAME_CHECKSUM_EN` defined:
  - The `GET_CHK` state exists.
  - `CHK` must equal `ID ^ P2 ^ P1 ^ P0`; a mismatch is a bad frame.
  - Frame length is 6 bytes.
- `LINK_FRAME_CHECKSUM_EN` undefined:
  - No `GET_CHK` state and no XOR logic.
  - Validation and commit happen on `P0`.
  - Frame length is 5 bytes.
- The transmit side must be built with the same setting.

## Structure
- Package `link_frame_pkg`: the `SOF` default, the state encoding, the frame-length constant (5/6 depending on the macro), and a BCD-byte-valid function.
- One sub-module, `link_timer`: a loadable, clearable, saturating counter with an `expired` flag. It is instantiated twice: once for the byte timeout (16-bit), once for the link timeout (27-bit).

## Test plan
- Send `A5 03 01 23 45` (+`CHK` 0x64 with the macro) -> `ext_data`=0x03012345, one `ext_valid` pulse one cycle after the last strobe, `link_up`=1.
- Send `A5 03 01 2A 45` -> `frame_err` pulse, `err_cnt`=1, `ext_data` unchanged.
- Send `A5 03 01`, then idle for `BYTE_TIMEOUT` cycles, then a good frame with ID 0x02 -> one error, then `ext_data`=0x02xxxxxx.
- Send `A5 03 A5 02 00 00 09` (+`CHK` 0x0B) -> one resync error, then `ext_data`=0x02000009.
- With the macro: a good frame with `CHK` 0x00 -> rejected, `err_cnt`+1.
- One good frame, then silence for `LINK_TIMEOUT` cycles -> `link_up` falls to 0 and `ext_data` is retained. Then assert `rst` low mid-frame -> all outputs return to 0.

Source files
------------

// File: rtl/link_frame_pkg.sv
// Shared constants, state encoding and BCD check for the score-link frame receiver.
// LINK_FRAME_CHECKSUM_EN adds the trailing XOR checksum byte to the frame format.
package link_frame_pkg;

    localparam logic [7:0] SofDefault = 8'hA5;

`ifdef LINK_FRAME_CHECKSUM_EN
    localparam int unsigned FrameLen = 6;

    typedef enum logic [2:0] {
        StIdle,
        StGetId,
        StGetP2,
        StGetP1,
        StGetP0,
        StGetChk
    } rx_state_e;
`else
    localparam int unsigned FrameLen = 5;

    typedef enum logic [2:0] {
        StIdle,
        StGetId,
        StGetP2,
        StGetP1,
        StGetP0
    } rx_state_e;
`endif

    function automatic logic bcd_byte_valid(input logic [7:0] b);
        return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
    endfunction

endpackage

// File: rtl/link_timer.sv
// Loadable, clearable up-counter that saturates at limit_i; expired_o is high once it gets there.
module link_timer #(
    parameter int unsigned Width = 16
) (
    input  logic             pclk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic [Width-1:0] limit_i,
    output logic             expired_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q < limit_i)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge pclk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q >= limit_i);

endmodule

// File: rtl/link_frame_rx.sv
// Receive-side frame assembler: finds SOF-framed {ID, BCD points} words in a UART byte stream.
// Define LINK_FRAME_CHECKSUM_EN to require the trailing CHK = ID^P2^P1^P0 byte.
module link_frame_rx
    import link_frame_pkg::*;
#(
    parameter logic [7:0]  SOF          = SofDefault,
    parameter int unsigned BYTE_TIMEOUT = 26040,
    parameter int unsigned LINK_TIMEOUT = 75_000_000
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [31:0] ext_data,
    output logic        ext_valid,
    output logic        link_up,
    output logic        frame_err,
    output logic [7:0]  err_cnt
);

    localparam logic [15:0] ByteLimit = 16'(BYTE_TIMEOUT);
    localparam logic [26:0] LinkLimit = 27'(LINK_TIMEOUT);

    rx_state_e   state_q, state_d;
    logic [7:0]  id_q, id_d, p2_q, p2_d, p1_q, p1_d;
    logic [31:0] ext_data_q, ext_data_d;
    logic        ext_valid_q, ext_valid_d;
    logic        frame_err_q, frame_err_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic        seen_good_q, seen_good_d;
    logic        commit, reject, frame_ok, byte_expired, link_expired;
    logic [7:0]  p0_cand;

`ifdef LINK_FRAME_CHECKSUM_EN
    logic [7:0] p0_q, p0_d;
    logic       chk_ok;

    assign p0_cand = p0_q;
    assign chk_ok  = (rx_data == (id_q ^ p2_q ^ p1_q ^ p0_q));
    assign frame_ok = (id_q != 8'h00) && (id_q != SOF) && bcd_byte_valid(p2_q)
                      && bcd_byte_valid(p1_q) && bcd_byte_valid(p0_cand) && chk_ok;
`else
    // Without a checksum the frame closes on P0, so validate the live byte.
    assign p0_cand = rx_data;
    assign frame_ok = (id_q != 8'h00) && (id_q != SOF) && bcd_byte_valid(p2_q)
                      && bcd_byte_valid(p1_q) && bcd_byte_valid(p0_cand);
`endif

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        p2_d        = p2_q;
        p1_d        = p1_q;
`ifdef LINK_FRAME_CHECKSUM_EN
        p0_d        = p0_q;
`endif
        ext_data_d  = ext_data_q;
        ext_valid_d = 1'b0;
        frame_err_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        seen_good_d = seen_good_q;
        commit      = 1'b0;
        reject      = 1'b0;

        // A byte arriving on the expiry cycle wins over the timeout.
        if ((state_q != StIdle) && !rx_valid && byte_expired) begin
            state_d = StIdle;
            reject  = 1'b1;
        end else if (rx_valid) begin
            case (state_q)
                StIdle: begin
                    if (rx_data == SOF) state_d = StGetId;
                end
                StGetId: begin
                    id_d    = rx_data;
                    state_d = StGetP2;
                end
                StGetP2: begin
                    if (rx_data == SOF) begin
                        reject  = 1'b1;
                        state_d = StGetId;
                    end else begin
                        p2_d    = rx_data;
                        state_d = StGetP1;
                    end
                end
                StGetP1: begin
                    if (rx_data == SOF) begin
                        reject  = 1'b1;
                        state_d = StGetId;
                    end else begin
                        p1_d    = rx_data;
                        state_d = StGetP0;
                    end
                end
                StGetP0: begin
                    if (rx_data == SOF) begin
                        reject  = 1'b1;
                        state_d = StGetId;
                    end else begin
`ifdef LINK_FRAME_CHECKSUM_EN
                        p0_d    = rx_data;
                        state_d = StGetChk;
`else
                        commit  = frame_ok;
                        reject  = !frame_ok;
                        state_d = StIdle;
`endif
                    end
                end
`ifdef LINK_FRAME_CHECKSUM_EN
                StGetChk: begin
                    commit  = frame_ok;
                    reject  = !frame_ok;
                    state_d = StIdle;
                end
`endif
                default: state_d = StIdle;
            endcase
        end

        if (commit) begin
            ext_data_d  = {id_q, p2_q, p1_q, p0_cand};
            ext_valid_d = 1'b1;
            seen_good_d = 1'b1;
        end
        if (reject) begin
            frame_err_d = 1'b1;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            id_q        <= '0;
            p2_q        <= '0;
            p1_q        <= '0;
            ext_data_q  <= '0;
            ext_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            err_cnt_q   <= '0;
            seen_good_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            p2_q        <= p2_d;
            p1_q        <= p1_d;
            ext_data_q  <= ext_data_d;
            ext_valid_q <= ext_valid_d;
            frame_err_q <= frame_err_d;
            err_cnt_q   <= err_cnt_d;
            seen_good_q <= seen_good_d;
        end
    end

`ifdef LINK_FRAME_CHECKSUM_EN
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            p0_q <= '0;
        end else begin
            p0_q <= p0_d;
        end
    end
`endif

    link_timer #(
        .Width (16)
    ) u_byte_timer (
        .pclk_i     (pclk),
        .rst_ni     (rst),
        .en_i       (state_q != StIdle),
        .clr_i      (rx_valid || (state_q == StIdle)),
        .load_i     (1'b0),
        .load_val_i (16'd0),
        .limit_i    (ByteLimit),
        .expired_o  (byte_expired)
    );

    link_timer #(
        .Width (27)
    ) u_link_timer (
        .pclk_i     (pclk),
        .rst_ni     (rst),
        .en_i       (1'b1),
        .clr_i      (commit),
        .load_i     (1'b0),
        .load_val_i (27'd0),
        .limit_i    (LinkLimit),
        .expired_o  (link_expired)
    );

    assign ext_data  = ext_data_q;
    assign ext_valid = ext_valid_q;
    assign frame_err = frame_err_q;
    assign err_cnt   = err_cnt_q;
    assign link_up   = seen_good_q && !link_expired;

endmodule

// File: tb/tb_link_frame_rx.sv
// Directed bench for link_frame_rx with shortened timeouts; follows LINK_FRAME_CHECKSUM_EN.
module tb_link_frame_rx;
    import link_frame_pkg::*;

    localparam int unsigned ByteTo = 20;
    localparam int unsigned LinkTo = 300;

    logic        pclk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [31:0] ext_data;
    logic        ext_valid;
    logic        link_up;
    logic        frame_err;
    logic [7:0]  err_cnt;

    int          total = 0;
    int          bad = 0;
    logic [7:0]  exp_err = 8'd0;

    always #5 pclk = ~pclk;

    link_frame_rx #(
        .SOF          (8'hA5),
        .BYTE_TIMEOUT (ByteTo),
        .LINK_TIMEOUT (LinkTo)
    ) dut (
        .pclk      (pclk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .ext_data  (ext_data),
        .ext_valid (ext_valid),
        .link_up   (link_up),
        .frame_err (frame_err),
        .err_cnt   (err_cnt)
    );

    // Called 1 time unit after a rising edge; returns 1 unit after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge pclk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] id, input logic [7:0] p2,
                              input logic [7:0] p1, input logic [7:0] p0);
        logic [7:0] bytes [6];
        bytes = '{8'hA5, id, p2, p1, p0, id ^ p2 ^ p1 ^ p0};
        for (int i = 0; i < int'(FrameLen); i++) send_byte(bytes[i]);
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        @(posedge pclk);
        #1;
        total++; if (ext_data !== 32'h0) begin bad++; $display("FAIL reset_data: got %h want 0", ext_data); end
        total++; if (ext_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", ext_valid); end
        total++; if (link_up !== 1'b0) begin bad++; $display("FAIL reset_link: got %b want 0", link_up); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
        total++; if (err_cnt !== 8'h0) begin bad++; $display("FAIL reset_cnt: got %h want 0", err_cnt); end
        @(posedge pclk);
        #1 rst = 1'b1;
    endtask

    task automatic test_good_frame();
        send_frame(8'h03, 8'h01, 8'h23, 8'h45);
        total++; if (ext_valid !== 1'b1) begin bad++; $display("FAIL good_valid: got %b want 1", ext_valid); end
        total++; if (ext_data !== 32'h03012345) begin bad++; $display("FAIL good_data: got %h want 03012345", ext_data); end
        total++; if (link_up !== 1'b1) begin bad++; $display("FAIL good_link: got %b want 1", link_up); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL good_ferr: got %b want 0", frame_err); end
        @(posedge pclk);
        #1;
        total++; if (ext_valid !== 1'b0) begin bad++; $display("FAIL good_valid_pulse: got %b want 0", ext_valid); end
    endtask

    task automatic test_bad_bcd();
        send_frame(8'h03, 8'h01, 8'h2A, 8'h45);
        exp_err++;
        total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL bcd_ferr: got %b want 1", frame_err); end
        total++; if (err_cnt !== exp_err) begin bad++; $display("FAIL bcd_cnt: got %h want %h", err_cnt, exp_err); end
        total++; if (ext_valid !== 1'b0) begin bad++; $display("FAIL bcd_valid: got %b want 0", ext_valid); end
        total++; if (ext_data !== 32'h03012345) begin bad++; $display("FAIL bcd_data: got %h want 03012345", ext_data); end
        @(posedge pclk);
        #1;
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL bcd_ferr_pulse: got %b want 0", frame_err); end
    endtask

    task automatic test_bad_id();
        send_frame(8'h00, 8'h01, 8'h02, 8'h03);
        exp_err++;
        total++; if (err_cnt !== exp_err) begin bad++; $display("FAIL id0_cnt: got %h want %h", err_cnt, exp_err); end
        send_frame(8'hA5, 8'h01, 8'h02, 8'h03);
        exp_err++;
        total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL idsof_ferr: got %b want 1", frame_err); end
        total++; if (err_cnt !== exp_err) begin bad++; $display("FAIL idsof_cnt: got %h want %h", err_cnt, exp_err); end
        total++; if (ext_data !== 32'h03012345) begin bad++; $display("FAIL id_data: got %h want 03012345", ext_data); end
    endtask

    task automatic test_byte_timeout();
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h01);
        repeat (ByteTo) @(posedge pclk);
        #1;
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL to_early: got %b want 0", frame_err); end
        @(posedge pclk);
        #1;
        exp_err++;
        total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL to_ferr: got %b want 1", frame_err); end
        total++; if (err_cnt !== exp_err) begin bad++; $display("FAIL to_cnt: got %h want %h", err_cnt, exp_err); end
        send_frame(8'h02, 8'h00, 8'h12, 8'h34);
        total++; if (ext_data !== 32'h02001234) begin bad++; $display("FAIL to_data: got %h want 02001234", ext_data); end
    endtask

    task automatic test_byte_boundary();
        send_byte(8'hA5);
        send_byte(8'h05);
        send_byte(8'h01);
        repeat (ByteTo) @(posedge pclk);
        #1;
        send_byte(8'h23);
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL bnd_ferr: got %b want 0", frame_err); end
        send_byte(8'h45);
`ifdef LINK_FRAME_CHECKSUM_EN
        send_byte(8'h62);
`endif
        total++; if (ext_valid !== 1'b1) begin bad++; $display("FAIL bnd_valid: got %b want 1", ext_valid); end
        total++; if (ext_data !== 32'h05012345) begin bad++; $display("FAIL bnd_data: got %h want 05012345", ext_data); end
        total++; if (err_cnt !== exp_err) begin bad++; $display("FAIL bnd_cnt: got %h want %h", err_cnt, exp_err); end
    endtask

    task automatic test_resync();
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'hA5);
        exp_err++;
        total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL rs_ferr: got %b want 1", frame_err); end
        total++; if (err_cnt !== exp_err) begin bad++; $display("FAIL rs_cnt: got %h want %h", err_cnt, exp_err); end
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h09);
`ifdef LINK_FRAME_CHECKSUM_EN
        send_byte(8'h0B);
`endif
        total++; if (ext_valid !== 1'b1) begin bad++; $display("FAIL rs_valid: got %b want 1", ext_valid); end
        total++; if (ext_data !== 32'h02000009) begin bad++; $display("FAIL rs_data: got %h want 02000009", ext_data); end
    endtask

`ifdef LINK_FRAME_CHECKSUM_EN
    task automatic test_checksum();
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h01);
        send_byte(8'h23);
        send_byte(8'h45);
        send_byte(8'h00);
        exp_err++;
        total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL chk_ferr: got %b want 1", frame_err); end
        total++; if (err_cnt !== exp_err) begin bad++; $display("FAIL chk_cnt: got %h want %h", err_cnt, exp_err); end
        total++; if (ext_data !== 32'h02000009) begin bad++; $display("FAIL chk_data: got %h want 02000009", ext_data); end
    endtask
`endif

    task automatic test_back_to_back();
        send_frame(8'h04, 8'h00, 8'h00, 8'h01);
        total++; if (ext_data !== 32'h04000001) begin bad++; $display("FAIL b2b_data1: got %h want 04000001", ext_data); end
        send_frame(8'h06, 8'h99, 8'h99, 8'h99);
        total++; if (ext_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid2: got %b want 1", ext_valid); end
        total++; if (ext_data !== 32'h06999999) begin bad++; $display("FAIL b2b_data2: got %h want 06999999", ext_data); end
    endtask

    task automatic test_link_timeout();
        send_frame(8'h07, 8'h00, 8'h00, 8'h42);
        repeat (LinkTo - 1) @(posedge pclk);
        #1;
        total++; if (link_up !== 1'b1) begin bad++; $display("FAIL lt_still_up: got %b want 1", link_up); end
        @(posedge pclk);
        #1;
        total++; if (link_up !== 1'b0) begin bad++; $display("FAIL lt_down: got %b want 0", link_up); end
        total++; if (ext_data !== 32'h07000042) begin bad++; $display("FAIL lt_data: got %h want 07000042", ext_data); end
        send_frame(8'h08, 8'h00, 8'h00, 8'h01);
        total++; if (link_up !== 1'b1) begin bad++; $display("FAIL lt_recover: got %b want 1", link_up); end
    endtask

    task automatic test_reset_mid_frame();
        send_byte(8'hA5);
        send_byte(8'h07);
        rst = 1'b0;
        #1;
        total++; if (ext_data !== 32'h0) begin bad++; $display("FAIL mid_data: got %h want 0", ext_data); end
        total++; if (link_up !== 1'b0) begin bad++; $display("FAIL mid_link: got %b want 0", link_up); end
        total++; if (err_cnt !== 8'h0) begin bad++; $display("FAIL mid_cnt: got %h want 0", err_cnt); end
        total++; if (ext_valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b want 0", ext_valid); end
        @(posedge pclk);
        #1 rst = 1'b1;
        send_byte(8'h01);
        send_byte(8'h23);
        send_byte(8'h45);
        send_byte(8'h64);
        total++; if (ext_valid !== 1'b0) begin bad++; $display("FAIL mid_discard_valid: got %b want 0", ext_valid); end
        total++; if (ext_data !== 32'h0) begin bad++; $display("FAIL mid_discard_data: got %h want 0", ext_data); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL mid_discard_ferr: got %b want 0", frame_err); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_bcd();
        test_bad_id();
        test_byte_timeout();
        test_byte_boundary();
        test_resync();
`ifdef LINK_FRAME_CHECKSUM_EN
        test_checksum();
`endif
        test_back_to_back();
        test_link_timeout();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
